// File: rtl/memory_pkg.sv
// memory_pkg: constants shared by the memory access controller and its response FIFO.
package memory_pkg;
  localparam int RSP_DEPTH_MIN = 2;
  localparam logic REQ_READ = 1'b0;
  localparam logic REQ_WRITE = 1'b1;
endpackage

// File: rtl/memory_access_controller_fifo.sv
// response_fifo: in-order read-data buffer with occupancy count.
module response_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  always_comb begin
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    wr_d = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller: valid/ready front end for a dual-port memory with 1-cycle read latency,
// returning read data in order through a credit-limited response FIFO.
module memory_access_controller
  import memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     mem_enable_write,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_enable_read,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);
  localparam int DEPTH = RSP_DEPTH < RSP_DEPTH_MIN ? RSP_DEPTH_MIN : RSP_DEPTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 3);
  logic en_wr_q, en_wr_d, en_rd_q, en_rd_d, s2_q, s2_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic req_fire, wr_fire, rd_fire, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] outstanding;
  // every read holds a credit from issue until its response is popped, so the FIFO never overflows
  always_comb begin
    outstanding = OW'(en_rd_q) + OW'(s2_q) + OW'(fifo_count);
    req_ready = outstanding < OW'(DEPTH);
    req_fire = req_valid && req_ready;
    wr_fire = req_fire && req_write == REQ_WRITE;
    rd_fire = req_fire && req_write == REQ_READ;
    en_wr_d = wr_fire;
    en_rd_d = rd_fire;
    s2_d = en_rd_q;
    wa_d = wr_fire ? req_address : wa_q;
    wd_d = wr_fire ? req_wdata : wd_q;
    ra_d = rd_fire ? req_address : ra_q;
  end
  always_ff @(posedge clka) begin
    if (rsta) begin
      en_wr_q <= 1'b0;
      en_rd_q <= 1'b0;
      s2_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      ra_q <= '0;
    end else begin
      en_wr_q <= en_wr_d;
      en_rd_q <= en_rd_d;
      s2_q <= s2_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      ra_q <= ra_d;
    end
  end
  assign mem_enable_write = en_wr_q;
  assign mem_write_address = wa_q;
  assign mem_write_data = wd_q;
  assign mem_enable_read = en_rd_q;
  assign mem_read_address = ra_q;
  assign rsp_valid = !fifo_empty;
  response_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i   (clka),
    .rst_i   (rsta),
    .push_i  (s2_q && !fifo_full),
    .wdata_i (mem_read_data),
    .pop_i   (rsp_ready),
    .rdata_o (rsp_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
endmodule
